// File: rtl/apb_timer_pkg.sv
// Shared register map, CTRL bit positions and reset values for the APB timer.
// Optional EXTIN event-counter support is selected with APB_TIMER_EXTIN_EN.
package apb_timer_pkg;

  localparam logic [7:0] CTRL_OFS      = 8'h00;
  localparam logic [7:0] LOAD_OFS      = 8'h04;
  localparam logic [7:0] VALUE_OFS     = 8'h08;
  localparam logic [7:0] PRESCALE_OFS  = 8'h0C;
  localparam logic [7:0] INTSTATUS_OFS = 8'h10;

  localparam int unsigned CTRL_EN      = 0;
  localparam int unsigned CTRL_IRQEN   = 1;
  localparam int unsigned CTRL_ONESHOT = 2;
  localparam int unsigned CTRL_EXTEN   = 3;
  localparam int unsigned CTRL_W       = 4;

  localparam logic [CTRL_W-1:0] CTRL_RST      = '0;
  localparam logic [31:0]       LOAD_RST      = '0;
  localparam logic [31:0]       VALUE_RST     = '0;
  localparam logic [31:0]       PRESCALE_RST  = '0;
  localparam logic              INTSTATUS_RST = 1'b0;

  typedef enum logic [2:0] {
    SEL_CTRL,
    SEL_LOAD,
    SEL_VALUE,
    SEL_PRESCALE,
    SEL_INTSTATUS,
    SEL_NONE
  } reg_sel_e;

  function automatic reg_sel_e decode_sel(input logic [31:0] word_idx);
    reg_sel_e sel;
    case (word_idx)
      32'(CTRL_OFS >> 2):      sel = SEL_CTRL;
      32'(LOAD_OFS >> 2):      sel = SEL_LOAD;
      32'(VALUE_OFS >> 2):     sel = SEL_VALUE;
      32'(PRESCALE_OFS >> 2):  sel = SEL_PRESCALE;
      32'(INTSTATUS_OFS >> 2): sel = SEL_INTSTATUS;
      default:                 sel = SEL_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/apb_timer_if.sv
// APB2 slave bus bundle (no PREADY/PSLVERR) between the bridge and the timer.
interface apb_timer_if #(
  parameter int unsigned ADDR_W = 12
);
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [31:0]       PWDATA;
  logic [31:0]       PRDATA;

  modport master (output PSEL, PENABLE, PWRITE, PADDR, PWDATA, input PRDATA);
  modport slave  (input PSEL, PENABLE, PWRITE, PADDR, PWDATA, output PRDATA);
endinterface

// File: rtl/apb_timer_prescaler.sv
// Prescaler counting 0..limit and pulsing tick_o at the terminal count.
// With APB_TIMER_EXTIN_EN it can instead advance on synchronised EXTIN rising edges.
module apb_timer_prescaler
  import apb_timer_pkg::*;
#(
  parameter int unsigned PRESCALE_W = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  enable_i,
  input  logic                  clear_i,
  input  logic [PRESCALE_W-1:0] limit_i,
`ifdef APB_TIMER_EXTIN_EN
  input  logic                  ext_en_i,
  input  logic                  extin_i,
`endif
  output logic                  tick_o
);

  logic [PRESCALE_W-1:0] cnt_q, cnt_d;
  logic                  advance;

`ifdef APB_TIMER_EXTIN_EN
  logic [2:0] sync_q;
  logic       edge_q;

  // Two synchroniser stages, one history stage, then a registered edge pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], extin_i};
      edge_q <= sync_q[1] & ~sync_q[2];
    end
  end

  assign advance = enable_i & (~ext_en_i | edge_q);
`else
  assign advance = enable_i;
`endif

  assign tick_o = advance & (cnt_q == limit_i);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i || tick_o) begin
      cnt_d = '0;
    end else if (advance) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/apb_timer.sv
// Zero-wait-state APB2 down-counting timer with prescaler, one-shot mode and level IRQ.
// Define APB_TIMER_EXTIN_EN to add the EXTIN port and CTRL.EXTEN event-counter mode.
module apb_timer
  import apb_timer_pkg::*;
#(
  parameter int unsigned PRESCALE_W = 16,
  parameter int unsigned ADDR_W     = 12
) (
  input  logic       PCLK,
  input  logic       PRESETn,
  apb_timer_if.slave apb,
`ifdef APB_TIMER_EXTIN_EN
  input  logic       EXTIN,
`endif
  output logic       TIMERINT
);

`ifdef APB_TIMER_EXTIN_EN
  localparam logic [CTRL_W-1:0] CTRL_WMASK = 4'hF;
`else
  localparam logic [CTRL_W-1:0] CTRL_WMASK = 4'h7;
`endif

  logic [CTRL_W-1:0]     ctrl_q, ctrl_d;
  logic [31:0]           load_q, load_d;
  logic [31:0]           value_q, value_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic                  intstat_q, intstat_d;

  logic [ADDR_W-3:0] word_idx;
  reg_sel_e          sel;
  logic              wr_commit;
  logic              sw_value_wr;
  logic              pre_clear;
  logic              tick;
  logic              tick_eff;
  logic              unused_addr_lsb;

  assign word_idx        = apb.PADDR[ADDR_W-1:2];
  assign unused_addr_lsb = ^apb.PADDR[1:0];
  assign sel             = decode_sel(32'(word_idx));
  assign wr_commit       = apb.PSEL & apb.PENABLE & apb.PWRITE;
  assign sw_value_wr     = wr_commit & ((sel == SEL_LOAD) | (sel == SEL_VALUE));
  assign pre_clear       = sw_value_wr
                         | (wr_commit & (sel == SEL_CTRL) & apb.PWDATA[CTRL_EN] & ~ctrl_q[CTRL_EN]);
  assign tick_eff        = tick & ~sw_value_wr;

  apb_timer_prescaler #(
    .PRESCALE_W(PRESCALE_W)
  ) u_prescaler (
    .clk_i    (PCLK),
    .rst_ni   (PRESETn),
    .enable_i (ctrl_q[CTRL_EN]),
    .clear_i  (pre_clear),
    .limit_i  (prescale_q),
`ifdef APB_TIMER_EXTIN_EN
    .ext_en_i (ctrl_q[CTRL_EXTEN]),
    .extin_i  (EXTIN),
`endif
    .tick_o   (tick)
  );

  always_comb begin
    ctrl_d     = ctrl_q;
    load_d     = load_q;
    value_d    = value_q;
    prescale_d = prescale_q;
    intstat_d  = intstat_q;

    if (wr_commit && (sel == SEL_INTSTATUS) && apb.PWDATA[0]) begin
      intstat_d = 1'b0;
    end

    // Expiry is applied before software writes so a register write overrides it,
    // while the hardware set of INTSTATUS still beats a same-cycle W1C.
    if (tick_eff) begin
      if (value_q != '0) begin
        value_d = value_q - 32'd1;
      end else begin
        intstat_d = 1'b1;
        if (ctrl_q[CTRL_ONESHOT]) begin
          ctrl_d[CTRL_EN] = 1'b0;
        end else begin
          value_d = load_q;
        end
      end
    end

    if (wr_commit) begin
      case (sel)
        SEL_CTRL:     ctrl_d     = apb.PWDATA[CTRL_W-1:0] & CTRL_WMASK;
        SEL_LOAD: begin
          load_d  = apb.PWDATA;
          value_d = apb.PWDATA;
        end
        SEL_VALUE:    value_d    = apb.PWDATA;
        SEL_PRESCALE: prescale_d = apb.PWDATA[PRESCALE_W-1:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      ctrl_q     <= CTRL_RST;
      load_q     <= LOAD_RST;
      value_q    <= VALUE_RST;
      prescale_q <= PRESCALE_RST[PRESCALE_W-1:0];
      intstat_q  <= INTSTATUS_RST;
    end else begin
      ctrl_q     <= ctrl_d;
      load_q     <= load_d;
      value_q    <= value_d;
      prescale_q <= prescale_d;
      intstat_q  <= intstat_d;
    end
  end

  always_comb begin
    apb.PRDATA = '0;
    if (apb.PSEL && !apb.PWRITE) begin
      case (sel)
        SEL_CTRL:      apb.PRDATA = 32'(ctrl_q);
        SEL_LOAD:      apb.PRDATA = load_q;
        SEL_VALUE:     apb.PRDATA = value_q;
        SEL_PRESCALE:  apb.PRDATA = 32'(prescale_q);
        SEL_INTSTATUS: apb.PRDATA = {31'b0, intstat_q};
        default:       apb.PRDATA = '0;
      endcase
    end
  end

  assign TIMERINT = intstat_q & ctrl_q[CTRL_IRQEN];

endmodule

// File: tb/tb_apb_timer.sv
// Scoreboard bench for apb_timer: directed timing checks plus random APB traffic vs a reference model.
`timescale 1ns/1ps
module tb_apb_timer;
  import apb_timer_pkg::*;

  localparam int unsigned ADDR_W = 12;
`ifdef APB_TIMER_EXTIN_EN
  localparam logic [31:0] M_CTRL_MASK = 32'hF;
`else
  localparam logic [31:0] M_CTRL_MASK = 32'h7;
`endif

  logic PCLK    = 1'b0;
  logic PRESETn = 1'b0;
  logic TIMERINT;
  apb_timer_if #(.ADDR_W(ADDR_W)) apb ();
`ifdef APB_TIMER_EXTIN_EN
  logic extin = 1'b0;
`endif

  apb_timer #(.PRESCALE_W(16), .ADDR_W(ADDR_W)) dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .apb     (apb),
`ifdef APB_TIMER_EXTIN_EN
    .EXTIN   (extin),
`endif
    .TIMERINT(TIMERINT)
  );

  always #5 PCLK = ~PCLK;

  int total = 0;
  int bad   = 0;
  bit chk_int = 1'b1;

  logic [31:0] exp_q[$];
  string       name_q[$];

  // Reference model state (plain register contents plus prescaler phase).
  logic [31:0] m_ctrl = '0, m_load = '0, m_value = '0, m_pre = '0, m_cnt = '0;
  logic        m_ist  = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [31:0] a);
    case (a[ADDR_W-1:2])
      0:       return m_ctrl;
      1:       return m_load;
      2:       return m_value;
      3:       return m_pre;
      4:       return {31'b0, m_ist};
      default: return '0;
    endcase
  endfunction

  task automatic m_reset();
    m_ctrl = '0; m_load = '0; m_value = '0; m_pre = '0; m_cnt = '0; m_ist = 1'b0;
  endtask

  task automatic m_step();
    logic [31:0] w, nc, nl, nv, np, nn;
    bit wr, en, tick, swv, ni;
    wr   = apb.PSEL && apb.PENABLE && apb.PWRITE;
    w    = 32'(apb.PADDR[ADDR_W-1:2]);
    en   = m_ctrl[0];
    tick = en && (m_cnt == m_pre);
    nn   = !en ? m_cnt : (tick ? 32'd0 : ((m_cnt + 1) & 32'hFFFF));
    nc = m_ctrl; nl = m_load; nv = m_value; np = m_pre; ni = m_ist;
    swv  = wr && (w == 1 || w == 2);
    if (wr && w == 4 && apb.PWDATA[0]) ni = 1'b0;
    if (tick && !swv) begin
      if (m_value != 0) nv = m_value - 1;
      else begin
        ni = 1'b1;
        if (m_ctrl[2]) nc[0] = 1'b0;
        else nv = m_load;
      end
    end
    if (wr) begin
      case (w)
        0: begin if (!en && apb.PWDATA[0]) nn = 0; nc = apb.PWDATA & M_CTRL_MASK; end
        1: begin nl = apb.PWDATA; nv = apb.PWDATA; nn = 0; end
        2: begin nv = apb.PWDATA; nn = 0; end
        3: np = apb.PWDATA & 32'hFFFF;
        default: ;
      endcase
    end
    m_ctrl = nc; m_load = nl; m_value = nv; m_pre = np; m_cnt = nn; m_ist = ni;
  endtask

  initial begin : model
    forever begin
      @(posedge PCLK or negedge PRESETn);
      if (!PRESETn) m_reset();
      else m_step();
    end
  end

  initial begin : monitor
    logic [31:0] e;
    string nm;
    forever begin
      @(negedge PCLK);
      if (PRESETn && chk_int)
        check("timerint", 32'(TIMERINT), 32'(m_ist & m_ctrl[1]));
      if (apb.PSEL && apb.PENABLE && !apb.PWRITE) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL sb_underflow: read data %h with no expectation", apb.PRDATA);
        end else begin
          e  = exp_q.pop_front();
          nm = name_q.pop_front();
          check(nm, apb.PRDATA, e);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge PCLK); #1; end
  endtask

  task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
    apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b1;
    apb.PADDR = a[ADDR_W-1:0]; apb.PWDATA = d;
    @(posedge PCLK); #1;
    apb.PENABLE = 1'b1;
    @(posedge PCLK); #1;
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [31:0] a, input bit use_model,
                          input logic [31:0] exp, input string nm);
    apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
    apb.PADDR = a[ADDR_W-1:0];
    @(posedge PCLK); #1;
    exp_q.push_back(use_model ? m_read(a) : exp);
    name_q.push_back(nm);
    apb.PENABLE = 1'b1;
    @(posedge PCLK); #1;
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0;
  endtask

  task automatic wait_int(input int exp_n, input string nm);
    int n = 0;
    while (!TIMERINT && n < 200) begin @(posedge PCLK); #1; n++; end
    check(nm, n, exp_n);
  endtask

  task automatic do_reset();
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
    apb.PADDR = '0; apb.PWDATA = '0;
    #2 PRESETn = 1'b0;
    #1 check("rst_async_int", 32'(TIMERINT), 32'd0);
    @(negedge PCLK); @(negedge PCLK);
    PRESETn = 1'b1;
    @(posedge PCLK); #1;
  endtask

  task automatic read_all_zero(input string nm);
    for (int a = 0; a <= 'h14; a += 4) apb_read(a, 1'b0, 32'd0, nm);
    check({nm, "_int"}, 32'(TIMERINT), 32'd0);
  endtask

  initial begin : stim
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
    apb.PADDR = '0; apb.PWDATA = '0;
    do_reset();
    read_all_zero("rst_regs");

    // Periodic: period (3+1)*(1+1) = 8 cycles.
    apb_write('h04, 3); apb_write('h0C, 1); apb_write('h00, 3);
    wait_int(8, "per_first");
    for (int k = 0; k < 2; k++) begin
      apb_write('h10, 1);
      check("per_w1c", 32'(TIMERINT), 32'd0);
      wait_int(6, "per_next");
    end

    do_reset();
    apb_write('h04, 2); apb_write('h00, 7);
    wait_int(3, "os_expire");
    apb_read('h00, 1'b0, 32'h6, "os_ctrl");
    apb_read('h08, 1'b0, 32'h0, "os_value");
    idle(10);
    apb_read('h08, 1'b0, 32'h0, "os_value_hold");
    apb_read('h10, 1'b0, 32'h1, "os_ist");
    check("os_int_hold", 32'(TIMERINT), 32'd1);

    do_reset();
    apb_write('h04, 3); apb_write('h0C, 1); apb_write('h00, 3);
    idle(6);
    apb_write('h10, 1);
    apb_read('h10, 1'b0, 32'h1, "w1c_vs_set");
    check("w1c_vs_set_int", 32'(TIMERINT), 32'd1);

    do_reset();
    apb_write('h04, 'h20); apb_write('h0C, 1); apb_write('h00, 1);
    apb_write('h08, 'h10);
    apb_read('h08, 1'b0, 32'h10, "wr_vs_tick");
    apb_read('h08, 1'b0, 32'h0F, "wr_vs_tick_dec");

    do_reset();
    apb_write('h00, 'h8);
`ifdef APB_TIMER_EXTIN_EN
    apb_read('h00, 1'b0, 32'h8, "ctrl_bit3");
`else
    apb_read('h00, 1'b0, 32'h0, "ctrl_bit3");
`endif
    apb_write('h14, 32'hFFFF_FFFF);
    apb_read('h14, 1'b0, 32'h0, "unmapped");
    apb_write('h0C, 32'hFFFF_FFFF);
    apb_read('h0C, 1'b0, 32'h0000_FFFF, "prescale_width");

    do_reset();
    apb_write('h04, 1); apb_write('h00, 3);
    wait_int(2, "pre_rst_int");
    do_reset();
    read_all_zero("post_rst");

`ifdef APB_TIMER_EXTIN_EN
    chk_int = 1'b0;
    apb_write('h04, 1); apb_write('h00, 'hB);
    idle(10);
    apb_read('h08, 1'b0, 32'h1, "ext_no_edge");
    extin = 1'b1; idle(2); extin = 1'b0; idle(4);
    apb_read('h08, 1'b0, 32'h0, "ext_first");
    check("ext_no_int", 32'(TIMERINT), 32'd0);
    extin = 1'b1;
    wait_int(4, "ext_latency");
    extin = 1'b0;
    do_reset();
    chk_int = 1'b1;
`endif

    for (int i = 0; i < 400; i++) begin
      int unsigned op, r;
      logic [31:0] d;
      op = $urandom_range(0, 9);
      r  = $urandom_range(0, 6);
      if (op < 4) begin
        case (r)
          0:       d = $urandom_range(0, 7);
          1, 2:    d = $urandom_range(0, 6);
          3:       d = $urandom_range(0, 3);
          default: d = $urandom;
        endcase
        apb_write(r * 4, d);
      end else if (op < 8) begin
        apb_read(r * 4, 1'b1, 32'd0, "rd_rand");
      end else begin
        idle($urandom_range(1, 5));
      end
    end

    idle(3);
    check("sb_drain", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
